// File: rtl/shift_arbiter_seq.sv
// shift_arbiter_seq
//
// Two requesters share one staged shift datapath. A round-robin arbiter
// grants one request at a time. The shift then runs as five conditional
// stages (16, 8, 4, 2, 1), one stage per clock. The result is held until
// the consumer takes it. Supported operations are SLL, SRL and SRA. Op code
// 11 passes the operand through unchanged.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// - A requester raises reqN_valid and holds data, shamt and op stable until
//   it sees reqN_ready.
// - reqN_ready is combinational and high only in IDLE for the granted
//   requester. At most one ready is high at a time.
// - rsp_valid stays high, with rsp_data and rsp_id stable, until rsp_ready
//   is seen.
//
// Ports:
//   clk, rst_n                  clock; synchronous active-low reset
//   req0_valid/ready/data/      requester 0: handshake, operand,
//     shamt/op                  shift amount, op (00 SLL, 01 SRL, 10 SRA)
//   req1_*                      requester 1, same meaning as requester 0
//   rsp_valid/ready             result handshake
//   rsp_data                    shifted result
//   rsp_id                      index of the requester that owns rsp_data
//   busy                        high whenever the FSM is not in IDLE
//   dbg_state                   current FSM state (0 IDLE, 1 SHIFT, 2 RESP)
module shift_arbiter_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [1:0]         req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [1:0]         req1_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_id,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  // The stage counter indexes the shamt bits from MSB down to LSB.
  localparam int K_W = $clog2(SHAMT_W);
  localparam logic [K_W-1:0] K_INIT = K_W'(SHAMT_W - 1);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_next;

  // Captured operation and working accumulator.
  logic [WIDTH-1:0]   acc_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [1:0]         op_q;
  logic               id_q;
  logic               sign_q;
  logic [K_W-1:0]     k_q;
  // Round-robin pointer: the requester that wins when both are valid.
  logic               rr_ptr_q;

  // Arbitration and accept decode.
  logic               grant0, grant1;
  logic               accept0, accept1, accept;
  logic               sel_id;
  logic [WIDTH-1:0]   sel_data;
  logic [SHAMT_W-1:0] sel_shamt;
  logic [1:0]         sel_op;

  // Shift stage datapath.
  logic               stage_hit;
  logic [SHAMT_W-1:0] stage_amt;
  logic [WIDTH-1:0]   right_fill;
  logic [WIDTH-1:0]   stage_out;
  logic [WIDTH-1:0]   acc_next;

  // ------------------------------------------------------------------
  // Arbitration. A lone valid requester always wins. When both are
  // valid, the pointer decides.
  // ------------------------------------------------------------------
  assign grant0 = req0_valid && (!req1_valid || !rr_ptr_q);
  assign grant1 = req1_valid && (!req0_valid ||  rr_ptr_q);

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;
  assign accept  = accept0 || accept1;
  assign sel_id  = accept1;

  always_comb begin
    sel_data  = req0_data;
    sel_shamt = req0_shamt;
    sel_op    = req0_op;
    if (sel_id) begin
      sel_data  = req1_data;
      sel_shamt = req1_shamt;
      sel_op    = req1_op;
    end
  end

  // ------------------------------------------------------------------
  // One shift stage. The stage at counter k moves the accumulator by
  // 2^k when shamt bit k is set. SRA fills the vacated high bits with the
  // sign captured at accept. The live accumulator MSB changes once
  // shifting starts, so it cannot be used as the fill.
  // ------------------------------------------------------------------
  assign stage_hit  = shamt_q[k_q];
  assign stage_amt  = SHAMT_W'(1) << k_q;
  assign right_fill = ~({WIDTH{1'b1}} >> stage_amt);

  always_comb begin
    stage_out = acc_q;
    case (op_q)
      OP_SLL:  stage_out = acc_q << stage_amt;
      OP_SRL:  stage_out = acc_q >> stage_amt;
      OP_SRA:  stage_out = (acc_q >> stage_amt) | (sign_q ? right_fill : '0);
      default: stage_out = acc_q;
    endcase
  end

  assign acc_next = stage_hit ? stage_out : acc_q;

  // ------------------------------------------------------------------
  // FSM: next state and outputs.
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_id     = 1'b0;
    busy       = 1'b1;

    case (state)
      IDLE: begin
        busy = 1'b0;
        // Keep ready low while reset is asserted. Otherwise a requester
        // could see a handshake that the reset edge throws away.
        req0_ready = rst_n && grant0;
        req1_ready = rst_n && grant1;
        if (accept) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // The shift has no early exit. It always takes five cycles, even
        // when shamt is zero.
        if (k_q == '0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = acc_q;
        rsp_id    = id_q;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign dbg_state = state;

  // ------------------------------------------------------------------
  // FSM state register.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ------------------------------------------------------------------
  // Datapath registers. On reset any in-flight operation is dropped.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      shamt_q  <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      sign_q   <= 1'b0;
      k_q      <= '0;
      rr_ptr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_q    <= sel_data;
            shamt_q  <= sel_shamt;
            op_q     <= sel_op;
            id_q     <= sel_id;
            sign_q   <= sel_data[WIDTH-1];
            k_q      <= K_INIT;
            // The other requester gets priority next time.
            rr_ptr_q <= ~sel_id;
          end
        end
        SHIFT: begin
          acc_q <= acc_next;
          if (k_q != '0) begin
            k_q <= k_q - K_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter_seq.sv
module tb_shift_arbiter_seq;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst_n;
  logic               req0_valid, req0_ready;
  logic [WIDTH-1:0]   req0_data;
  logic [SHAMT_W-1:0] req0_shamt;
  logic [1:0]         req0_op;
  logic               req1_valid, req1_ready;
  logic [WIDTH-1:0]   req1_data;
  logic [SHAMT_W-1:0] req1_shamt;
  logic [1:0]         req1_op;
  logic               rsp_valid, rsp_ready;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_id;
  logic               busy;
  logic [1:0]         dbg_state;

  always #5 clk = ~clk;

  shift_arbiter_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shamt (req0_shamt),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shamt (req1_shamt),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_id_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic id, input logic [31:0] d, input logic [4:0] s,
                           input logic [1:0] op, input logic v);
    if (!id) begin
      req0_valid = v; req0_data = d; req0_shamt = s; req0_op = op;
    end else begin
      req1_valid = v; req1_data = d; req1_shamt = s; req1_op = op;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge. Raises valid, waits for ready, and lets the accept
  // edge pass. Returns at the first negedge after the accept.
  task automatic issue(input string name, input logic id, input logic [31:0] d,
                       input logic [4:0] s, input logic [1:0] op,
                       input logic [31:0] exp_data, input bit expect_now);
    int   waits = 0;
    logic rdy;
    drive_req(id, d, s, op, 1'b1);
    #1;
    rdy = id ? req1_ready : req0_ready;
    while (!rdy && waits < 30) begin
      @(negedge clk); #1;
      waits++;
      rdy = id ? req1_ready : req0_ready;
    end
    if (!rdy) begin
      errors++; checks++;
      $display("FAIL %s accept: ready never seen within 30 cycles", name);
      drive_req(id, d, s, op, 1'b0);
      return;
    end
    if (expect_now) check({name, " ready_same_cycle"}, 32'(waits), 32'd0);
    check({name, " other_ready_low"}, 32'(id ? req0_ready : req1_ready), 32'd0);
    exp_q.push_back(exp_data);
    exp_id_q.push_back(id);
    @(posedge clk);
    @(negedge clk);
    drive_req(id, d, s, op, 1'b0);
  endtask

  // Called at the first negedge after the accept. Measures latency and
  // optionally holds rsp_ready low for 'hold' cycles. Then takes the result
  // and checks it against the scoreboard.
  task automatic collect(input string name, input int hold);
    int lat = 0;
    int bad = 0;
    int bad_hold = 0;
    logic [WIDTH-1:0] e;
    logic             eid;
    rsp_ready = (hold == 0);
    while (!rsp_valid && lat < 20) begin
      if (!busy || req0_ready || req1_ready) bad++;
      @(posedge clk); lat++;
      @(negedge clk);
    end
    check({name, " latency"}, 32'(lat), 32'd5);
    check({name, " busy_no_ready_in_shift"}, 32'(bad), 32'd0);
    if (exp_q.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s scoreboard: expected queue empty", name);
      rsp_ready = 1'b1;
      return;
    end
    e   = exp_q.pop_front();
    eid = exp_id_q.pop_front();
    if (!rsp_valid) begin
      rsp_ready = 1'b1;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      if (!rsp_valid || rsp_data !== e || rsp_id !== eid || req0_ready || req1_ready || !busy)
        bad_hold++;
      @(posedge clk);
      @(negedge clk);
    end
    if (hold > 0) check({name, " held_stable"}, 32'(bad_hold), 32'd0);
    rsp_ready = 1'b1;
    check({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({name, " rsp_data"}, rsp_data, e);
    check({name, " rsp_id"}, 32'(rsp_id), 32'(eid));
    @(posedge clk);
    @(negedge clk);
    check({name, " rsp_valid_after_hs"}, 32'(rsp_valid), 32'd0);
    check({name, " busy_after_hs"}, 32'(busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        id;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int cyc, n_acc, n_rsp, bad;
    int   acc_cyc[4];
    logic acc_id[4];

    vecs[0]  = '{1'b0, 32'h0000_00F1,  5'd4, 2'b00, 32'h0000_0F10};
    vecs[1]  = '{1'b1, 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF};
    vecs[2]  = '{1'b1, 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001};
    vecs[3]  = '{1'b0, 32'hDEAD_BEEF,  5'd7, 2'b11, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 32'h1234_5678,  5'd0, 2'b10, 32'h1234_5678};
    vecs[5]  = '{1'b1, 32'hF000_0000,  5'd4, 2'b10, 32'hFF00_0000};
    vecs[6]  = '{1'b0, 32'h7FFF_FFFF,  5'd1, 2'b10, 32'h3FFF_FFFF};
    vecs[7]  = '{1'b1, 32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000};
    vecs[8]  = '{1'b0, 32'hA5A5_A5A5, 5'd16, 2'b01, 32'h0000_A5A5};
    vecs[9]  = '{1'b1, 32'h0000_0001, 5'd21, 2'b00, 32'h0020_0000};
    vecs[10] = '{1'b0, 32'h8000_0000,  5'd5, 2'b10, 32'hFC00_0000};
    vecs[11] = '{1'b0, 32'hCAFE_F00D,  5'd8, 2'b01, 32'h00CA_FEF0};

    rsp_ready  = 1'b1;
    req0_data  = '0; req0_shamt = '0; req0_op = '0;
    req1_data  = '0; req1_shamt = '0; req1_op = '0;

    // Reset state, with a request pending while reset is held.
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req0_ready", 32'(req0_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    check("reset rsp_id", 32'(rsp_id), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single operations.
    for (int i = 0; i < 12; i++) begin
      issue($sformatf("vec%0d", i), vecs[i].id, vecs[i].data, vecs[i].shamt,
            vecs[i].op, vecs[i].exp_data, 1'b1);
      collect($sformatf("vec%0d", i), 0);
    end

    // Back-pressure: hold rsp_ready low for 10 cycles while req1 waits.
    issue("hold0", 1'b0, 32'h1234_5678, 5'd0, 2'b00, 32'h1234_5678, 1'b1);
    drive_req(1'b1, 32'h0000_000F, 5'd1, 2'b00, 1'b1);
    collect("hold0", 10);
    #1;
    check("hold req1_ready_after_hs", 32'(req1_ready), 32'd1);
    check("hold req0_ready_after_hs", 32'(req0_ready), 32'd0);
    issue("hold1", 1'b1, 32'h0000_000F, 5'd1, 2'b00, 32'h0000_001E, 1'b1);
    collect("hold1", 0);

    // Round robin: both valid continuously right after reset.
    do_reset();
    drive_req(1'b0, 32'h0000_0001, 5'd1, 2'b00, 1'b1);
    drive_req(1'b1, 32'h0000_0080, 5'd3, 2'b01, 1'b1);
    rsp_ready = 1'b1;
    cyc = 0; n_acc = 0; n_rsp = 0; bad = 0;
    while (n_rsp < 4 && cyc < 100) begin
      #1;
      if (req0_ready && req1_ready) bad++;
      if (n_acc < 4 && (req0_ready || req1_ready)) begin
        acc_cyc[n_acc] = cyc;
        acc_id[n_acc]  = req1_ready;
        n_acc++;
      end
      if (rsp_valid) begin
        check($sformatf("rr rsp_id%0d", n_rsp), 32'(rsp_id), 32'(n_rsp % 2));
        check($sformatf("rr rsp_data%0d", n_rsp), rsp_data,
              (n_rsp % 2 == 1) ? 32'h0000_0010 : 32'h0000_0002);
        n_rsp++;
      end
      if (n_rsp < 4) begin
        @(negedge clk);
        cyc++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rr responses", 32'(n_rsp), 32'd4);
    check("rr accepts", 32'(n_acc), 32'd4);
    check("rr both_ready", 32'(bad), 32'd0);
    for (int i = 0; i < n_acc; i++)
      check($sformatf("rr grant%0d", i), 32'(acc_id[i]), 32'(i % 2));
    for (int i = 0; i + 1 < n_acc; i++)
      check($sformatf("rr interval%0d", i), 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd7);
    @(posedge clk);
    @(negedge clk);
    check("rr busy_end", 32'(busy), 32'd0);

    // Reset during the third SHIFT cycle. Accepting req0 first makes the
    // pointer favour req1, so the later grant shows the pointer was reset.
    issue("rst_mid", 1'b0, 32'h0F0F_0000, 5'd2, 2'b01, 32'h03C3_C000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    void'(exp_q.pop_front());
    void'(exp_id_q.pop_front());
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid state", 32'(dbg_state), 32'd0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid || busy) bad++;
      @(negedge clk);
    end
    check("rst_mid no_rsp", 32'(bad), 32'd0);
    drive_req(1'b0, 32'h0000_0003, 5'd2, 2'b00, 1'b1);
    drive_req(1'b1, 32'h0000_00F0, 5'd4, 2'b01, 1'b1);
    #1;
    check("rst_mid prio req0_ready", 32'(req0_ready), 32'd1);
    check("rst_mid prio req1_ready", 32'(req1_ready), 32'd0);
    issue("post0", 1'b0, 32'h0000_0003, 5'd2, 2'b00, 32'h0000_000C, 1'b1);
    collect("post0", 0);
    issue("post1", 1'b1, 32'h0000_00F0, 5'd4, 2'b01, 32'h0000_000F, 1'b1);
    collect("post1", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_arbiter_seq.md
Name: shift_arbiter_seq

Overview:
- Multi-cycle shift controller that shares one staged 32-bit shift datapath between two requesters, for example the integer ALU issue port and the CSR/address-generation port.
- Round-robin arbitration picks one requester at a time.
- The operation is sequenced as five conditional stages (16, 8, 4, 2, 1), one stage per clock.
- Each request and the result use a valid/ready handshake.
- Supports SLL, SRL and SRA.

Parameters:
- WIDTH, 32, data width in bits; must be 32 for RV32.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  reset, synchronous, active-low
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_data  input  WIDTH  operand to shift
- req0_shamt  input  SHAMT_W  shift amount
- req0_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved
- req1_valid, req1_ready, req1_data, req1_shamt, req1_op: same widths and meaning as above, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes the result
- rsp_data  output  WIDTH  shifted result
- rsp_id  output  1  index of the requester that owns rsp_data
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0
  - busy = 0
  - req0_ready = req1_ready = 0 during reset
  - round-robin pointer = 0, meaning requester 0 has priority next
- Reset mid-operation: the in-flight operation is discarded, no response is produced, and the block returns to IDLE on the next edge.
- States:
  - IDLE: wait for a request.
  - SHIFT: stage counter k counts down from 4 to 0.
  - RESP: hold the result until it is taken.
- IDLE, arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester indicated by the pointer.
  - reqN_ready = (state == IDLE) && grantN. This is combinational and at most one ready is high.
  - Accept when valid && ready on a rising edge. On that edge:
    - capture acc = data, shamt, op and id;
    - capture sign = data[WIDTH-1];
    - set k = 4;
    - pointer = ~id;
    - state goes to SHIFT.
- SHIFT, each edge:
  - If shamt[k] = 1, shift acc by 2^k; otherwise acc is unchanged.
  - Fill bits:
    - SLL: shift left, fill 0.
    - SRL: shift right, fill 0.
    - SRA: shift right, fill with the captured sign.
    - op 11: acc unchanged on every stage, so the result equals the input data.
  - If k = 0, state goes to RESP; otherwise k decrements.
  - There is no early exit: SHIFT always lasts exactly 5 cycles, including when shamt = 0.
- Latency: rsp_valid is high starting 5 rising edges after the accepting edge.
- RESP:
  - rsp_valid = 1, rsp_data = acc, rsp_id = captured id.
  - rsp_data and rsp_id stay stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid drops to 0 and state goes to IDLE.
  - No request can be accepted in the same cycle as the response handshake. The minimum issue interval is therefore 7 cycles: 1 accept + 5 shift + 1 resp.
- Ready is never asserted outside IDLE. A requester must hold its valid and payload stable until ready is seen; behaviour is undefined otherwise.
- shamt is taken modulo 32 by construction, since it is only 5 bits. A shift by 31 is legal.
- A requester whose valid is high while the block is busy just waits; its request is neither dropped nor buffered.

Test Plan:
- Reset, then req0 valid with data 0x0000_00F1, shamt 4, op SLL. Expect: req0_ready high in the same cycle; rsp_valid high 5 edges after acceptance with rsp_data 0x0000_0F10 and rsp_id 0; busy high from acceptance until the response handshake.
- req1 with data 0x8000_0000, shamt 31, op SRA. Expect rsp_data 0xFFFF_FFFF. Then the same data with op SRL. Expect rsp_data 0x0000_0001.
- req0 and req1 valid continuously right after reset, with rsp_ready always 1. Expect grants in the order 0, 1, 0, 1, checked via rsp_id, and an issue interval of 7 cycles.
- Hold rsp_ready = 0 for 10 cycles after rsp_valid rises, with data 0x1234_5678, shamt 0. Expect rsp_valid and rsp_data = 0x1234_5678 held constant, req*_ready kept 0 throughout, and acceptance in the cycle after rsp_ready rises.
- Pulse rst_n low during the third SHIFT cycle. Expect IDLE on the next edge, rsp_valid never asserted for that operation, busy = 0, and requester 0 given priority afterwards.
- Use op 11 with data 0xDEAD_BEEF, shamt 7. Expect rsp_data 0xDEAD_BEEF after the normal 5-cycle latency.
